// File: rtl/ddr_rd_burst_fetch.sv
// ddr_rd_burst_fetch: splits fetch commands into DDR read bursts and
// streams the returned beats through a credit-managed show-ahead FIFO.
module ddr_rd_burst_fetch #(
    parameter int ADDR_W     = 26,
    parameter int DATA_W     = 512,
    parameter int BL_W       = 7,
    parameter int MAX_BURST  = 64,
    parameter int FIFO_DEPTH = 128,
    parameter int LEN_W      = 16
) (
    input  logic              sync_clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              avl_ready,
    output logic              avl_read_req,
    output logic [ADDR_W-1:0] avl_addr,
    output logic [BL_W-1:0]   avl_size,
    input  logic              avl_rdata_valid,
    input  logic [DATA_W-1:0] avl_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int CR_W  = CNT_W + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t            state;
    logic [LEN_W-1:0]  len;
    logic [LEN_W-1:0]  remaining;
    logic [LEN_W-1:0]  rx_cnt;
    logic [CNT_W-1:0]  fifo_cnt;
    logic [CNT_W-1:0]  inflight;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              zero_done;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];

    logic              push;
    logic              pop;
    logic              accept;
    logic              burst_acc;
    logic [CR_W-1:0]   credit;
    logic [CR_W-1:0]   credit_after;
    logic [LEN_W-1:0]  rem_next;
    logic [BL_W-1:0]   size_next;
    logic [BL_W-1:0]   size_cmd;

    function automatic logic [BL_W-1:0] burst_of(input logic [LEN_W-1:0] r);
        return (r > LEN_W'(MAX_BURST)) ? BL_W'(MAX_BURST) : BL_W'(r);
    endfunction

    // Beats arriving with nothing outstanding (e.g. after reset) are dropped.
    assign push      = avl_rdata_valid && (inflight != '0);
    assign pop       = out_valid && out_ready;
    assign accept    = cmd_valid && cmd_ready;
    assign burst_acc = avl_read_req && avl_ready;

    assign credit       = CR_W'(FIFO_DEPTH) - CR_W'(fifo_cnt) - CR_W'(inflight);
    assign credit_after = credit - CR_W'(avl_size);
    assign rem_next     = remaining - LEN_W'(avl_size);
    assign size_next    = burst_of(rem_next);
    assign size_cmd     = burst_of(cmd_len);

    assign out_valid = (fifo_cnt != '0);
    assign out_data  = mem[rd_ptr];
    assign out_last  = out_valid && (rx_cnt == len - LEN_W'(1));
    assign busy      = (state != IDLE);
    assign done      = zero_done || ((state == DRAIN) && pop && out_last);

    always_ff @(posedge sync_clk) begin
        if (push)
            mem[wr_ptr] <= avl_rdata;
    end

    always_ff @(posedge sync_clk) begin
        if (reset) begin
            state        <= IDLE;
            cmd_ready    <= 1'b0;
            avl_read_req <= 1'b0;
            avl_addr     <= '0;
            avl_size     <= '0;
            len          <= '0;
            remaining    <= '0;
            rx_cnt       <= '0;
            fifo_cnt     <= '0;
            inflight     <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            zero_done    <= 1'b0;
        end else begin
            zero_done <= 1'b0;
            wr_ptr    <= wr_ptr + PTR_W'(push);
            rd_ptr    <= rd_ptr + PTR_W'(pop);
            inflight  <= inflight
                       + (burst_acc ? CNT_W'(avl_size) : '0)
                       - CNT_W'(push);
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
            if (pop)
                rx_cnt <= rx_cnt + 1'b1;

            unique case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (accept) begin
                        avl_addr  <= cmd_addr;
                        avl_size  <= size_cmd;
                        len       <= cmd_len;
                        remaining <= cmd_len;
                        rx_cnt    <= '0;
                        if (cmd_len == '0) begin
                            zero_done <= 1'b1;
                        end else begin
                            state        <= ISSUE;
                            cmd_ready    <= 1'b0;
                            avl_read_req <= (credit >= CR_W'(size_cmd));
                        end
                    end
                end
                ISSUE: begin
                    if (burst_acc) begin
                        avl_addr  <= avl_addr + ADDR_W'(avl_size);
                        avl_size  <= size_next;
                        remaining <= rem_next;
                        if (rem_next == '0) begin
                            state        <= DRAIN;
                            avl_read_req <= 1'b0;
                        end else begin
                            // Registered counts lag returns/pops: conservative.
                            avl_read_req <= (credit_after >= CR_W'(size_next));
                        end
                    end else if (!avl_read_req) begin
                        avl_read_req <= (credit >= CR_W'(avl_size));
                    end
                end
                DRAIN: begin
                    if (pop && out_last) begin
                        state     <= IDLE;
                        cmd_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_rd_burst_fetch.sv
// Directed bench for ddr_rd_burst_fetch with an in-order DDR controller
// model and a beat checker running from one sequential process.
module tb_ddr_rd_burst_fetch;
    logic          sync_clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [25:0]   cmd_addr = '0;
    logic [15:0]   cmd_len = '0;
    logic          avl_ready = 1'b1;
    logic          avl_read_req;
    logic [25:0]   avl_addr;
    logic [6:0]    avl_size;
    logic          avl_rdata_valid = 1'b0;
    logic [511:0]  avl_rdata = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [511:0]  out_data;
    logic          out_last;
    logic          busy;
    logic          done;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          out_mode = 1;
    int          lat_min = 4;
    int          lat_max = 4;
    int          last_due = 0;
    logic [25:0] bq_addr[$];
    int          bq_due[$];
    logic [25:0] log_addr[$];
    int          log_size[$];
    logic [25:0] exp_base = '0;
    int          exp_len = 0;
    int          mon_idx = 0;
    int          done_cnt = 0;
    bit          busy_seen = 0;
    bit          acc_seen = 0;

    always #5 sync_clk = ~sync_clk;

    ddr_rd_burst_fetch dut (
        .sync_clk        (sync_clk),
        .reset           (reset),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_addr        (cmd_addr),
        .cmd_len         (cmd_len),
        .avl_ready       (avl_ready),
        .avl_read_req    (avl_read_req),
        .avl_addr        (avl_addr),
        .avl_size        (avl_size),
        .avl_rdata_valid (avl_rdata_valid),
        .avl_rdata       (avl_rdata),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data),
        .out_last        (out_last),
        .busy            (busy),
        .done            (done)
    );

    function automatic logic [511:0] pat(input logic [25:0] a);
        return {16{a ^ 26'h2A5A5A5, 6'h15}};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Observe the current cycle, then advance to the next negedge and
    // drive the controller return data and consumer ready for it.
    task automatic tick();
        int due;
        int lat;
        logic [511:0] want;
        #1;
        if (cmd_valid && cmd_ready) begin
            exp_base = cmd_addr;
            exp_len  = int'(cmd_len);
            mon_idx  = 0;
            acc_seen = 1;
        end
        if (out_valid === 1'b1 && out_ready) begin
            want = pat(exp_base + 26'(mon_idx));
            checks++;
            assert (out_data === want && mon_idx < exp_len) else begin
                errors++;
                $error("FAIL beat_data idx=%0d obs=%0h exp=%0h",
                       mon_idx, out_data, want);
            end
            checks++;
            assert (out_last === (mon_idx == exp_len - 1)) else begin
                errors++;
                $error("FAIL beat_last idx=%0d obs=%0b exp=%0b",
                       mon_idx, out_last, (mon_idx == exp_len - 1));
            end
            mon_idx++;
        end
        if (done === 1'b1) done_cnt++;
        if (busy === 1'b1) busy_seen = 1;
        if (avl_read_req === 1'b1 && avl_ready) begin
            log_addr.push_back(avl_addr);
            log_size.push_back(int'(avl_size));
            lat = int'($urandom_range(lat_max, lat_min));
            for (int i = 0; i < int'(avl_size); i++) begin
                due = cyc + lat;
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                bq_addr.push_back(avl_addr + 26'(i));
                bq_due.push_back(due);
            end
        end
        @(negedge sync_clk);
        cyc++;
        if (out_mode == 2) out_ready = 1'($urandom_range(1, 0));
        else out_ready = (out_mode == 1);
        if (bq_addr.size() > 0 && bq_due[0] <= cyc) begin
            avl_rdata_valid = 1'b1;
            avl_rdata = pat(bq_addr.pop_front());
            void'(bq_due.pop_front());
        end else begin
            avl_rdata_valid = 1'b0;
            avl_rdata = '0;
        end
        #1;
    endtask

    task automatic send_cmd(input logic [25:0] a, input int n);
        cmd_addr  = a;
        cmd_len   = 16'(n);
        cmd_valid = 1'b1;
        acc_seen  = 0;
        for (int i = 0; i < 20 && !acc_seen; i++) tick();
        cmd_valid = 1'b0;
        chk("cmd_accept", acc_seen, 1);
    endtask

    task automatic wait_done(input int target, input int maxc);
        for (int i = 0; i < maxc && done_cnt < target; i++) tick();
        chk("done_seen", done_cnt, target);
    endtask

    task automatic chk_burst(input string tag, input int k,
                             input logic [25:0] a, input int s);
        if (k < log_addr.size()) begin
            chk(tag, log_addr[k], a);
            chk(tag, log_size[k], s);
        end else begin
            chk(tag, log_addr.size(), k + 1);
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_req", avl_read_req, 0);
        chk("rst_addr", avl_addr, 0);
        chk("rst_size", avl_size, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
    endtask

    initial begin
        int n0;
        int d0;

        tick();
        chk_reset_vals();
        tick();
        reset = 1'b0;
        tick();
        chk("post_rst_cmd_ready", cmd_ready, 1);

        // 200 beats from 0x100, four-cycle return, consumer always ready
        n0 = log_addr.size();
        d0 = done_cnt;
        send_cmd(26'h100, 200);
        chk("a_first_req", avl_read_req, 1);
        chk("a_first_addr", avl_addr, 26'h100);
        chk("a_first_size", avl_size, 64);
        chk("a_busy", busy, 1);
        wait_done(d0 + 1, 2000);
        chk("a_beats", mon_idx, 200);
        chk("a_bursts", log_addr.size() - n0, 4);
        chk_burst("a_b0", n0 + 0, 26'h100, 64);
        chk_burst("a_b1", n0 + 1, 26'h140, 64);
        chk_burst("a_b2", n0 + 2, 26'h180, 64);
        chk_burst("a_b3", n0 + 3, 26'h1C0, 8);
        chk("a_idle_busy", busy, 0);
        chk("a_idle_ready", cmd_ready, 1);
        repeat (5) tick();
        chk("a_done_once", done_cnt, d0 + 1);

        // zero-length command
        n0 = log_addr.size();
        busy_seen = 0;
        send_cmd(26'h55, 0);
        chk("b_done", done, 1);
        chk("b_busy", busy, 0);
        chk("b_req", avl_read_req, 0);
        tick();
        chk("b_done_pulse", done, 0);
        repeat (4) tick();
        chk("b_busy_never", busy_seen, 0);
        chk("b_no_bursts", log_addr.size() - n0, 0);

        // consumer stalled: credit limits issue to two bursts
        out_mode = 0;
        n0 = log_addr.size();
        d0 = done_cnt;
        send_cmd(26'h2000, 300);
        repeat (300) tick();
        chk("c_stall_bursts", log_addr.size() - n0, 2);
        chk("c_stall_req", avl_read_req, 0);
        chk("c_stall_valid", out_valid, 1);
        chk("c_stall_popped", mon_idx, 0);
        out_mode = 1;
        wait_done(d0 + 1, 3000);
        chk("c_beats", mon_idx, 300);
        chk("c_bursts", log_addr.size() - n0, 5);
        chk_burst("c_b3", n0 + 3, 26'h20C0, 64);
        chk_burst("c_b4", n0 + 4, 26'h2100, 44);

        // controller stalls a pending request; address wraps
        avl_ready = 1'b0;
        n0 = log_addr.size();
        d0 = done_cnt;
        send_cmd(26'h3FFFFE0, 96);
        for (int i = 0; i < 5; i++) begin
            chk("d_hold_req", avl_read_req, 1);
            chk("d_hold_addr", avl_addr, 26'h3FFFFE0);
            chk("d_hold_size", avl_size, 64);
            tick();
        end
        chk("d_no_accept", log_addr.size() - n0, 0);
        avl_ready = 1'b1;
        chk("d_still_req", avl_read_req, 1);
        wait_done(d0 + 1, 2000);
        chk("d_beats", mon_idx, 96);
        chk("d_bursts", log_addr.size() - n0, 2);
        chk_burst("d_b0", n0 + 0, 26'h3FFFFE0, 64);
        chk_burst("d_b1", n0 + 1, 26'h20, 32);

        // random consumer and return latency, 1000 beats
        out_mode = 2;
        lat_min  = 1;
        lat_max  = 10;
        n0 = log_addr.size();
        d0 = done_cnt;
        send_cmd(26'h10000, 1000);
        wait_done(d0 + 1, 20000);
        chk("e_beats", mon_idx, 1000);
        chk("e_bursts", log_addr.size() - n0, 16);
        chk_burst("e_last", n0 + 15, 26'h103C0, 40);

        // reset with 40 beats still owed by the controller
        out_mode = 0;
        lat_min  = 4;
        lat_max  = 4;
        n0 = log_addr.size();
        send_cmd(26'h500, 200);
        for (int i = 0; i < 400; i++) begin
            if (bq_addr.size() <= 40 && log_addr.size() - n0 >= 2) break;
            tick();
        end
        chk("f_pending", bq_addr.size(), 40);
        reset = 1'b1;
        tick();
        chk_reset_vals();
        reset = 1'b0;
        out_mode = 1;
        for (int i = 0; i < 200 && bq_addr.size() > 0; i++) tick();
        repeat (3) tick();
        chk("f_dropped", out_valid, 0);
        chk("f_idle_ready", cmd_ready, 1);
        chk("f_idle_busy", busy, 0);
        n0 = log_addr.size();
        d0 = done_cnt;
        send_cmd(26'h777, 5);
        wait_done(d0 + 1, 500);
        chk("f_beats", mon_idx, 5);
        chk("f_bursts", log_addr.size() - n0, 1);
        chk_burst("f_b0", n0, 26'h777, 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ddr_rd_burst_fetch.md
# ddr_rd_burst_fetch

Read-side DMA stage that sits directly upstream of the DDR controller's Avalon-style read port. It accepts a fetch command (start word address and length in 512-bit beats) and splits it into controller-legal bursts. Returned data goes through an internal show-ahead FIFO with credit-based flow control, and leaves as a valid/ready beat stream toward the accelerator's feature/weight loaders.

## Interface
- ADDR_W, 26, DDR word address width (one word = one 512-bit beat)
- DATA_W, 512, beat width
- BL_W, 7, avl_size width
- MAX_BURST, 64, largest burst issued (beats, ≤ 2^BL_W−1)
- FIFO_DEPTH, 128, return FIFO depth (power of two, ≥ MAX_BURST)
- LEN_W, 16, command length width (beats)

- sync_clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- cmd_valid  in  1  fetch command offered
- cmd_ready  out  1  block can accept a command
- cmd_addr  in  ADDR_W  start word address
- cmd_len  in  LEN_W  beats to fetch; 0 is legal
- avl_ready  in  1  controller accepts request this cycle
- avl_read_req  out  1  read burst request
- avl_addr  out  ADDR_W  burst start address
- avl_size  out  BL_W  burst length in beats
- avl_rdata_valid  in  1  returned beat valid
- avl_rdata  in  DATA_W  returned beat
- out_valid  out  1  beat available
- out_ready  in  1  consumer takes beat
- out_data  out  DATA_W  beat data
- out_last  out  1  final beat of current command
- busy  out  1  command in progress
- done  out  1  one-cycle pulse when a command completes

## Operation
- States: IDLE, ISSUE, DRAIN.
- IDLE: cmd_ready=1. A command is accepted on cmd_valid&&cmd_ready. It latches addr, len and remaining=len, and sets rx_cnt=0.
  - len≠0 → ISSUE.
  - len=0 → done pulses the next cycle and the state stays IDLE.
- ISSUE:
  - size = min(remaining, MAX_BURST).
  - credit = FIFO_DEPTH − fifo_count − inflight.
  - avl_read_req is raised only when credit ≥ size.
  - Once raised, req/addr/size are held stable until sampled with avl_ready=1. There is no withdrawal.
  - On accept: addr += size; remaining −= size; inflight += size. If remaining becomes 0 → DRAIN.
- Returned beats: each avl_rdata_valid writes one FIFO entry and decrements inflight. Credit guarantees the FIFO never overflows. A valid beat with inflight=0 is dropped.
- out_last = out_valid && (popped count == len−1).
- DRAIN: completes when the beat with out_last is popped (out_valid&&out_ready). done pulses that same cycle and the state returns to IDLE the next cycle.
- busy = (state≠IDLE).
- Addresses wrap modulo 2^ADDR_W. There is no boundary splitting beyond MAX_BURST.

## Timing
- Reset values: cmd_ready=0 during reset, 1 the cycle after; avl_read_req=0; avl_addr=0; avl_size=0; out_valid=0; out_last=0; busy=0; done=0. The FIFO, inflight and all counters are cleared.
- Reset mid-command abandons it. Beats still returning afterwards are dropped because inflight=0.
- Command accept to first avl_read_req: 1 cycle.
- Back-to-back bursts: the next request may assert in the cycle after the accept, giving one request per cycle when credit allows.
- avl_rdata_valid in cycle N → out_valid in cycle N+1 (registered write, show-ahead read).
- A simultaneous FIFO push and pop leaves fifo_count unchanged. The credit update in that cycle uses registered counts, which is conservative.
- The next command can be accepted the cycle after done.

## Test plan
- cmd_addr=0x100, cmd_len=200, avl_ready=1, controller returns data 4 cycles after accept, out_ready=1 → bursts (0x100,64), (0x140,64), (0x180,64), (0x1C0,8). 200 beats emerge in order with out_last on beat 199. done pulses once.
- cmd_len=0 → no avl_read_req; done pulses 1 cycle after accept; busy never rises.
- cmd_len=300, out_ready=0 throughout → exactly 2 bursts of 64 issue (128 credits). No third request appears until out_ready releases. There is no FIFO overflow.
- avl_ready low for 5 cycles while a request is pending → avl_read_req, avl_addr and avl_size stay constant until the ready cycle. Exactly one accept is counted.
- Random out_ready at 50% with 1–10 cycles return latency, cmd_len=1000 → data matches the address-derived pattern and no beats are lost or duplicated.
- Assert reset mid-burst, with 40 beats still to return → all outputs go to reset values. The late beats are dropped. A new cmd_len=5 afterwards completes correctly.
